mvu_ic_xbar: RTL

Parametrised, flow-controlled successor to the MVU interconnect: an NMVU-port crossbar carrying data-bank words between MVUs. Each receiver selects one source. Words fan out (multicast) to every receiver subscribed to the same sender, and land in a per-receiver FIFO with valid/ready backpressure, so a slow consumer stalls its source instead of losing data. It sits between the MVU interconnect read ports (rdi_*) and write ports (wri_*) in the top level.

---
 rtl/mvu_pkg.sv | 19 +
 rtl/ic_fifo.sv | 61 ++++++
 rtl/mvu_ic_xbar.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mvu_pkg.sv
// -----------------------------------------------------------------------------
// mvu_pkg
// Shared constants for the MVU interconnect crossbar:
//   DROP_CNT_W    - width of each per-sender drop counter
//   BW_DEFAULT    - default word width (N of the MVUs)
//   DEPTH_DEFAULT - default entries per receiver FIFO
//   src_idx_w()   - source-index width (BMVUA) for a given port count
// -----------------------------------------------------------------------------
package mvu_pkg;

    localparam int DROP_CNT_W    = 16;
    localparam int BW_DEFAULT    = 64;
    localparam int DEPTH_DEFAULT = 4;

    function automatic int src_idx_w(input int nmvu);
        return (nmvu > 1) ? $clog2(nmvu) : 1;
    endfunction

endpackage

// File: rtl/ic_fifo.sv
// -----------------------------------------------------------------------------
// ic_fifo
// Single-clock show-ahead FIFO for one crossbar receiver.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers only)
//   clr          synchronous flush
//   push, din    write request and data (ignored when full)
//   pop          read request (ignored when empty)
//   dout         head word, forced to zero while empty
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module ic_fifo #(
    parameter int BW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [BW-1:0] din,
    input  logic          pop,
    output logic [BW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [BW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/mvu_ic_xbar.sv
// -----------------------------------------------------------------------------
// mvu_ic_xbar
// NMVU-port flow-controlled crossbar between MVU data banks. Each receiver
// picks one sender; a granted word is pushed atomically into the FIFO of every
// subscriber of that sender. A sender whose subscribers include a full FIFO is
// stalled; a sender with no subscribers is granted and its word discarded.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous flush of all FIFOs, masks grants
//   send_en/send_word     per-sender offer and word (slice i at i*BW)
//   send_grnt             per-sender accept this cycle
//   recv_act/recv_from    per-receiver subscribe enable and source index
//   recv_en/recv_word     per-receiver FIFO head valid and word
//   recv_rdy              per-receiver pop
//   drop_cnt              (MVU_IC_STATS_EN only) per-sender count of words
//                         granted with no subscribers, saturating at 16'hFFFF
// Optional feature macro: MVU_IC_STATS_EN
// -----------------------------------------------------------------------------
module mvu_ic_xbar
    import mvu_pkg::*;
#(
    parameter  int NMVU  = 8,
    parameter  int BW    = BW_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int BMVUA = src_idx_w(NMVU)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [NMVU-1:0]       send_en,
    input  logic [NMVU*BW-1:0]    send_word,
    output logic [NMVU-1:0]       send_grnt,
    input  logic [NMVU-1:0]       recv_act,
    input  logic [NMVU*BMVUA-1:0] recv_from,
    output logic [NMVU-1:0]       recv_en,
    output logic [NMVU*BW-1:0]    recv_word,
    input  logic [NMVU-1:0]       recv_rdy
`ifdef MVU_IC_STATS_EN
    ,
    output logic [NMVU*DROP_CNT_W-1:0] drop_cnt
`endif
);

    logic [NMVU-1:0] sub [NMVU];   // sub[j][i]: receiver j listens to sender i
    logic [NMVU-1:0] has_sub;
    logic [NMVU-1:0] blocked;
    logic [NMVU-1:0] fifo_full;
    logic [NMVU-1:0] fifo_empty;
    logic [NMVU-1:0] fifo_push;
    logic [BW-1:0]   fifo_din [NMVU];

    // Out-of-range source indices simply never match a sender.
    always_comb begin
        for (int j = 0; j < NMVU; j++) begin
            for (int i = 0; i < NMVU; i++) begin
                sub[j][i] = recv_act[j] && (recv_from[j*BMVUA +: BMVUA] == BMVUA'(i));
            end
        end
    end

    // Grant depends only on FIFO flags and config, never on recv_rdy.
    always_comb begin
        has_sub = '0;
        blocked = '0;
        for (int i = 0; i < NMVU; i++) begin
            for (int j = 0; j < NMVU; j++) begin
                if (sub[j][i]) begin
                    has_sub[i] = 1'b1;
                    if (fifo_full[j]) blocked[i] = 1'b1;
                end
            end
        end
        send_grnt = send_en & ~blocked & {NMVU{rst_n && !clr}};
    end

    always_comb begin
        for (int j = 0; j < NMVU; j++) begin
            fifo_push[j] = 1'b0;
            fifo_din[j]  = '0;
            for (int i = 0; i < NMVU; i++) begin
                if (sub[j][i]) begin
                    fifo_push[j] = send_grnt[i];
                    fifo_din[j]  = send_word[i*BW +: BW];
                end
            end
        end
    end

    for (genvar j = 0; j < NMVU; j++) begin : g_rx
        ic_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .push  (fifo_push[j]),
            .din   (fifo_din[j]),
            .pop   (recv_rdy[j]),
            .dout  (recv_word[j*BW +: BW]),
            .full  (fifo_full[j]),
            .empty (fifo_empty[j])
        );
    end

    assign recv_en = ~fifo_empty;

`ifdef MVU_IC_STATS_EN
    logic [DROP_CNT_W-1:0] drop_q [NMVU];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NMVU; i++) drop_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NMVU; i++) drop_q[i] <= '0;
        end else begin
            for (int i = 0; i < NMVU; i++) begin
                if (send_grnt[i] && !has_sub[i] && (drop_q[i] != '1))
                    drop_q[i] <= drop_q[i] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NMVU; i++) begin : g_drop
        assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_q[i];
    end
`endif

endmodule
